// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared operation encoding, FSM states and operand width for calc_sequencer
package calc_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ADDSUB,
      MUL,
      DIV,
      DONE
   } state_t;

endpackage

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - sequenced 8-bit add/sub plus iterative shift-add multiply and restoring divide
module calc_sequencer
   import calc_pkg::*;
(
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 Busy,
   output logic                 Done,
   output logic [2*WIDTH-1:0]   Result,
   output logic                 OVR,
   output logic                 NEG,
   output logic                 ZERO
);

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic               ovr_q, ovr_d, neg_q, neg_d, zero_q, zero_d;

   logic               start_ok;
   logic [WIDTH-1:0]   b_eff, sum;
   logic [2*WIDTH-1:0] mul_term, mul_sum;
   logic [WIDTH:0]     rem_sh, rem_nx;
   logic               rem_ge;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         ovr_q   <= 1'b0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ovr_q   <= ovr_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      sr_d     = sr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      ovr_d    = ovr_q;
      neg_d    = neg_q;
      zero_d   = zero_q;

      start_ok = Start && (state_q == IDLE || state_q == DONE);
      b_eff    = (op_q == OP_SUB) ? (~b_q + 8'd1) : b_q;
      sum      = a_q + b_eff;
      // Multiplier bits are consumed LSB first, so the multiplicand is weighted by the iteration count.
      mul_term = sr_q[0] ? ({8'h00, a_q} << cnt_q) : 16'h0000;
      mul_sum  = acc_q + mul_term;
      rem_sh   = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
      rem_ge   = rem_sh >= {1'b0, b_q};
      rem_nx   = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;

      case (state_q)
         LOAD: begin
            cnt_d = '0;
            acc_d = '0;
            sr_d  = (op_q == OP_DIV) ? a_q : b_q;
            case (op_q)
               OP_ADD, OP_SUB: state_d = ADDSUB;
               OP_MUL:         state_d = MUL;
               default: begin
                  if (b_q == '0) begin
                     state_d = DONE;
                     res_d   = '0;
                     ovr_d   = 1'b1;
                     neg_d   = 1'b0;
                     zero_d  = 1'b1;
                  end else begin
                     state_d = DIV;
                  end
               end
            endcase
         end
         ADDSUB: begin
            state_d = DONE;
            res_d   = {{WIDTH{sum[WIDTH-1]}}, sum};
            ovr_d   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            neg_d   = sum[WIDTH-1];
            zero_d  = (sum == '0);
         end
         MUL: begin
            acc_d = mul_sum;
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
               res_d   = mul_sum;
               ovr_d   = 1'b0;
               neg_d   = 1'b0;
               zero_d  = (mul_sum == '0);
            end
         end
         DIV: begin
            acc_d = {7'b0, rem_nx};
            sr_d  = {sr_q[WIDTH-2:0], rem_ge};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
               res_d   = {rem_nx[WIDTH-1:0], sr_q[WIDTH-2:0], rem_ge};
               ovr_d   = 1'b0;
               neg_d   = 1'b0;
               zero_d  = ({rem_nx[WIDTH-1:0], sr_q[WIDTH-2:0], rem_ge} == '0);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (start_ok) begin
         state_d = LOAD;
         op_d    = op_t'(Op);
         a_d     = A;
         b_d     = B;
      end
   end

   assign Busy   = (state_q == LOAD) || (state_q == ADDSUB) || (state_q == MUL) || (state_q == DIV);
   assign Done   = (state_q == DONE);
   assign Result = res_q;
   assign OVR    = ovr_q;
   assign NEG    = neg_q;
   assign ZERO   = zero_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - scoreboard bench for calc_sequencer with directed vectors
module tb_calc_sequencer;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [1:0]  Op;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        Busy;
   logic        Done;
   logic [15:0] Result;
   logic        OVR;
   logic        NEG;
   logic        ZERO;

   typedef struct {
      logic [15:0] res;
      logic        ovr;
      logic        neg;
      logic        zero;
      int          lat;
      int          t0;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   calc_sequencer dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .Op     (Op),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result),
      .OVR    (OVR),
      .NEG    (NEG),
      .ZERO   (ZERO)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge Clock) begin
      if (!Reset && Done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(Done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result",  32'(Result), 32'(e.res));
            chk("ovr",     32'(OVR),    32'(e.ovr));
            chk("neg",     32'(NEG),    32'(e.neg));
            chk("zero",    32'(ZERO),   32'(e.zero));
            chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
         end
      end
   end

   // Called just after a rising edge; Start is sampled on the next edge (cycle N).
   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] res, input logic ovr, input logic neg,
                        input logic zero, input int lat);
      exp_t e;
      Op    = op;
      A     = a;
      B     = b;
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      e.res  = res;
      e.ovr  = ovr;
      e.neg  = neg;
      e.zero = zero;
      e.lat  = lat;
      e.t0   = cyc;
      sb.push_back(e);
   endtask

   task automatic drain(input logic [15:0] res);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 30) begin
         @(posedge Clock);
         k++;
      end
      #1;
      chk("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
      repeat (3) @(posedge Clock);
      #1;
      chk("result_hold", 32'(Result), 32'(res));
      chk("idle_busy", 32'(Busy), 32'd0);
   endtask

   initial begin
      Reset = 1'b1;
      Start = 1'b0;
      Op    = 2'b00;
      A     = 8'h00;
      B     = 8'h00;
      #1;
      chk("rst_busy",   32'(Busy),   32'd0);
      chk("rst_done",   32'(Done),   32'd0);
      chk("rst_result", 32'(Result), 32'd0);
      chk("rst_flags",  32'({OVR, NEG, ZERO}), 32'd0);
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(posedge Clock);
      #1;

      issue(2'b00, 8'h7F, 8'h01, 16'hFF80, 1'b1, 1'b1, 1'b0, 3);
      drain(16'hFF80);
      issue(2'b01, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1, 3);
      drain(16'h0000);
      issue(2'b01, 8'h80, 8'h01, 16'h007F, 1'b1, 1'b0, 1'b0, 3);
      drain(16'h007F);
      issue(2'b00, 8'hF0, 8'h05, 16'hFFF5, 1'b0, 1'b1, 1'b0, 3);
      drain(16'hFFF5);

      issue(2'b10, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 10);
      for (int k = 1; k <= 9; k++) begin
         @(negedge Clock);
         chk("mul_busy", 32'(Busy), 32'd1);
      end
      @(negedge Clock);
      chk("mul_busy_end", 32'(Busy), 32'd0);
      drain(16'hFE01);

      issue(2'b11, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 1'b0, 10);
      drain(16'h041C);
      issue(2'b11, 8'hFF, 8'h01, 16'h00FF, 1'b0, 1'b0, 1'b0, 10);
      drain(16'h00FF);
      issue(2'b11, 8'h05, 8'h09, 16'h0500, 1'b0, 1'b0, 1'b0, 10);
      drain(16'h0500);
      issue(2'b11, 8'h10, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
      drain(16'h0000);

      // Start re-pulsed at N+3 with different operands must not disturb the multiply.
      issue(2'b10, 8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0, 1'b0, 10);
      @(posedge Clock);
      @(posedge Clock);
      #1;
      Op = 2'b00; A = 8'h01; B = 8'h01; Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      drain(16'h0078);

      // Start held through DONE launches a second operation back to back.
      begin
         exp_t e;
         Op = 2'b00; A = 8'h7F; B = 8'h01; Start = 1'b1;
         @(posedge Clock);
         #1;
         e.res = 16'hFF80; e.ovr = 1'b1; e.neg = 1'b1; e.zero = 1'b0; e.lat = 3; e.t0 = cyc;
         sb.push_back(e);
         Op = 2'b01; A = 8'h05; B = 8'h05;
         repeat (3) @(posedge Clock);
         #1;
         Start = 1'b0;
         e.res = 16'h0000; e.ovr = 1'b0; e.neg = 1'b0; e.zero = 1'b1; e.lat = 3; e.t0 = cyc;
         sb.push_back(e);
         drain(16'h0000);
      end

      issue(2'b11, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 1'b0, 10);
      drain(16'h041C);

      // Multiply aborted by reset at N+5, after an ignored Start at N+3.
      Op = 2'b10; A = 8'hFF; B = 8'hFF; Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      #1;
      Op = 2'b00; A = 8'h01; B = 8'h01; Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      #1;
      Reset = 1'b1;
      #1;
      chk("abort_busy",   32'(Busy),   32'd0);
      chk("abort_done",   32'(Done),   32'd0);
      chk("abort_result", 32'(Result), 32'd0);
      chk("abort_flags",  32'({OVR, NEG, ZERO}), 32'd0);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      repeat (15) @(posedge Clock);
      #1;
      chk("abort_idle_busy", 32'(Busy), 32'd0);

      // Reset together with Start: Start is dropped.
      Reset = 1'b1;
      Op = 2'b00; A = 8'h02; B = 8'h03; Start = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      Start = 1'b0;
      @(negedge Clock);
      chk("rst_start_busy", 32'(Busy), 32'd0);
      repeat (6) @(posedge Clock);
      #1;
      chk("rst_start_result", 32'(Result), 32'd0);
      chk("final_queue", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high; ports named Clock and Reset.
REQ-002 Clock  input  1  rising-edge system clock.
REQ-003 Reset  input  1  asynchronous active-high clear of all state and outputs.
REQ-004 Start  input  1  operation request, sampled on rising Clock edge.
REQ-005 Op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 A  input  8  first operand.
REQ-007 B  input  8  second operand.
REQ-008 Busy  output  1  high from the cycle after Start is accepted through the last cycle before DONE.
REQ-009 Done  output  1  single-cycle pulse when Result and flags become valid.
REQ-010 Result  output  16  operation result, held until the next accepted Start.
REQ-011 OVR  output  1  add/sub two's-complement overflow, or divide-by-zero.
REQ-012 NEG  output  1  sign of the result, add/sub only.
REQ-013 ZERO  output  1  Result equals 16'h0000.

Function
REQ-014 SHALL use FSM states IDLE, LOAD, ADDSUB, MUL, DIV and DONE.
REQ-015 SHALL accept Start only in IDLE or DONE, capturing A, B and Op on that edge (cycle N), and enter LOAD at N+1.
REQ-016 SHALL ignore Start while Busy; captured operands SHALL NOT change mid-operation.
REQ-017 LOAD SHALL go to ADDSUB for Op 00/01, MUL for 10, DIV for 11 when B!=0, and DONE for 11 when B==0.
REQ-018 Add/sub SHALL treat operands as signed 8-bit; Result = 8-bit sum/difference sign-extended to 16 bits.
REQ-019 Add/sub OVR SHALL be (A[7]==B'[7]) && (S[7]!=A[7]), where B' is B for add and ~B+1 for sub; NEG = S[7].
REQ-020 ADDSUB SHALL last one cycle; Done SHALL be asserted at N+3.
REQ-021 MUL SHALL be an unsigned 8x8->16 shift-add, one multiplier bit per cycle, 8 cycles (N+2..N+9); Done at N+10; OVR=0, NEG=0.
REQ-022 DIV SHALL be unsigned restoring division, one quotient bit per cycle, 8 cycles; Done at N+10.
REQ-023 DIV Result SHALL be {remainder[7:0], quotient[7:0]}; OVR=0, NEG=0.
REQ-024 Divide-by-zero SHALL produce Result=16'h0000, OVR=1, NEG=0, ZERO=1, with Done at N+2.
REQ-025 SHALL count iterations with a 3-bit counter cleared in LOAD; MUL/DIV SHALL exit when the count wraps from 7.
REQ-026 DONE SHALL last exactly one cycle and then go to IDLE, unless Start is sampled in DONE, which goes to LOAD.
REQ-027 Result, OVR, NEG and ZERO SHALL update only on entry to DONE and SHALL hold until the next DONE.

Reset
REQ-028 Reset SHALL immediately force IDLE with Busy=0, Done=0, Result=16'h0000, OVR=0, NEG=0, ZERO=0, counter=0.
REQ-029 Reset asserted mid-operation SHALL abort it; Done SHALL NOT pulse for the aborted operation.
REQ-030 Reset asserted together with Start SHALL take priority; Start SHALL be ignored.

Structure
REQ-031 A shared package calc_pkg SHALL hold the op_t encoding, the state_t enum and the WIDTH=8 constant.
REQ-032 SHALL be one module with an FSM plus an iterative datapath (16-bit accumulator/remainder register, 8-bit shift register, counter); no sub-module is required.

Verification
REQ-033 Add 0x7F+0x01 -> Done at N+3; Result=16'hFF80, OVR=1, NEG=1, ZERO=0.
REQ-034 Sub 0x05-0x05 -> Result=16'h0000, ZERO=1, OVR=0, NEG=0.
REQ-035 Mul 0xFF*0xFF -> Done at N+10; Result=16'hFE01; Busy high N+1..N+9.
REQ-036 Div 200/7 -> Done at N+10; Result=16'h041C (remainder 4, quotient 28).
REQ-037 Div 0x10/0x00 -> Done at N+2; Result=16'h0000, OVR=1, ZERO=1.
REQ-038 Mul started, Start re-pulsed at N+3, Reset at N+5 -> second Start ignored; all outputs 0 immediately on Reset; no Done pulse.
